// File: rtl/matrix_result_scanner.sv
// Display stage for the N x N matrix multiplier result: captures the flattened
// matrix on load and walks it element by element onto the LEDs with row/col.
module matrix_result_scanner #(
  parameter int N        = 5,
  parameter int ELEM_W   = 8,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [N*N*ELEM_W-1:0]   matrix_in,
  input  logic                    sw,
  input  logic                    step,
  output logic [ELEM_W-1:0]       leds,
  output logic [2:0]              row,
  output logic [2:0]              col,
  output logic                    busy,
  output logic                    done
);

  localparam int PW = $clog2(TICK_DIV);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHOW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0]    LAST_IDX = 5'(N*N-1);
  localparam logic [2:0]    LAST_COL = 3'(N-1);
  localparam logic [PW-1:0] TICK_TOP = PW'(TICK_DIV-1);

  logic [1:0]        state;
  logic [4:0]        idx;
  logic [PW-1:0]     prescaler;
  logic              step_q;
  logic [ELEM_W-1:0] shadow [N*N];

  logic tick;
  logic step_rise;
  logic advance;

  always_comb begin
    tick      = 1'b0;
    step_rise = step & ~step_q;
    advance   = 1'b0;
    if (state == SHOW) begin
      tick    = sw && (prescaler == TICK_TOP);
      // Step edges only count while paused; with sw=1 the tick owns the scan.
      advance = tick || (!sw && step_rise);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      prescaler <= '0;
      leds      <= '0;
      row       <= '0;
      col       <= '0;
      for (int unsigned i = 0; i < N*N; i++) begin
        shadow[i] <= '0;
      end
    end else if (load) begin
      state     <= SHOW;
      idx       <= '0;
      prescaler <= '0;
      leds      <= matrix_in[ELEM_W-1:0];
      row       <= '0;
      col       <= '0;
      for (int unsigned i = 0; i < N*N; i++) begin
        shadow[i] <= matrix_in[i*ELEM_W +: ELEM_W];
      end
    end else if (state == SHOW) begin
      if (sw) begin
        prescaler <= tick ? '0 : prescaler + PW'(1);
      end
      if (advance) begin
        if (idx == LAST_IDX) begin
          state <= DONE;
        end else begin
          // row/col are tracked incrementally alongside idx instead of dividing.
          idx  <= idx + 5'd1;
          leds <= shadow[idx + 5'd1];
          if (col == LAST_COL) begin
            col <= '0;
            row <= row + 3'd1;
          end else begin
            col <= col + 3'd1;
          end
        end
      end
    end
  end

  assign busy = (state == SHOW);
  assign done = (state == DONE);

endmodule

// File: tb/tb_matrix_result_scanner.sv
// Directed bench for matrix_result_scanner with a short tick divider.
module tb_matrix_result_scanner;

  localparam int N        = 5;
  localparam int ELEM_W   = 8;
  localparam int TICK_DIV = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  load = 1'b0;
  logic                  sw = 1'b0;
  logic                  step = 1'b0;
  logic [N*N*ELEM_W-1:0] matrix_in = '0;
  logic [ELEM_W-1:0]     leds;
  logic [2:0]            row;
  logic [2:0]            col;
  logic                  busy;
  logic                  done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matrix_result_scanner #(
    .N(N),
    .ELEM_W(ELEM_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .matrix_in(matrix_in),
    .sw(sw),
    .step(step),
    .leds(leds),
    .row(row),
    .col(col),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input int e_leds, input int e_row, input int e_col);
    chk({tag, " leds"}, 32'(leds), 32'(e_leds));
    chk({tag, " row"},  32'(row),  32'(e_row));
    chk({tag, " col"},  32'(col),  32'(e_col));
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic clkn(input int n);
    repeat (n) clk1();
  endtask

  task automatic fill_seq();
    for (int k = 0; k < N*N; k++) begin
      matrix_in[k*ELEM_W +: ELEM_W] = ELEM_W'(k + 1);
    end
  endtask

  initial begin
    // reset at power-up
    clkn(2);
    chk_disp("por", 0, 0, 0);
    chk("por busy", 32'(busy), 0);
    chk("por done", 32'(done), 0);
    rst = 1'b1;
    clkn(2);
    chk("idle busy", 32'(busy), 0);
    chk_disp("idle", 0, 0, 0);

    // auto scan, capture isolation, step ignored while sw=1
    fill_seq();
    sw = 1'b1;
    load = 1'b1;
    clk1();
    load = 1'b0;
    matrix_in = '1;
    chk_disp("auto k0", 1, 0, 0);
    chk("auto busy", 32'(busy), 1);
    chk("auto done", 32'(done), 0);
    for (int k = 1; k < N*N; k++) begin
      if (k == 1) begin
        step = 1'b1;
        clk1();
        step = 1'b0;
        clkn(2);
      end else begin
        clkn(3);
      end
      chk("auto hold", 32'(leds), 32'(k));
      clk1();
      chk_disp("auto adv", k + 1, k / N, k % N);
    end
    clkn(4);
    chk("auto end done", 32'(done), 1);
    chk("auto end busy", 32'(busy), 0);
    chk_disp("auto end", 25, 4, 4);
    sw = 1'b0;
    step = 1'b1;
    clk1();
    step = 1'b0;
    clkn(5);
    chk_disp("done step", 25, 4, 4);
    chk("done stays", 32'(done), 1);

    // asynchronous reset mid-scan
    fill_seq();
    sw = 1'b1;
    load = 1'b1;
    clk1();
    load = 1'b0;
    clkn(10);
    chk("pre-rst leds", 32'(leds), 3);
    #2;
    rst = 1'b0;
    #1;
    chk_disp("async rst", 0, 0, 0);
    chk("async rst busy", 32'(busy), 0);
    chk("async rst done", 32'(done), 0);
    #2;
    rst = 1'b1;
    clkn(6);
    chk_disp("post rst idle", 0, 0, 0);
    chk("post rst busy", 32'(busy), 0);

    // manual mode: held step counts once, then three pulses
    fill_seq();
    sw = 1'b0;
    load = 1'b1;
    clk1();
    load = 1'b0;
    step = 1'b1;
    clkn(10);
    chk_disp("man held", 2, 0, 1);
    step = 1'b0;
    clk1();
    repeat (3) begin
      step = 1'b1;
      clk1();
      step = 1'b0;
      clk1();
    end
    chk_disp("man pulses", 5, 0, 4);
    chk("man busy", 32'(busy), 1);
    clkn(8);
    chk("man paused", 32'(leds), 5);
    sw = 1'b1;
    clkn(3);
    chk("man resume hold", 32'(leds), 5);
    clk1();
    chk_disp("man resume adv", 6, 1, 0);

    // pause/resume keeps the prescaler value
    fill_seq();
    sw = 1'b0;
    load = 1'b1;
    clk1();
    load = 1'b0;
    sw = 1'b1;
    clkn(2);
    sw = 1'b0;
    clkn(20);
    chk("pause hold", 32'(leds), 1);
    sw = 1'b1;
    clk1();
    chk("resume +1", 32'(leds), 1);
    clk1();
    chk_disp("resume +2", 2, 0, 1);

    // load coinciding with tick at idx 7
    fill_seq();
    sw = 1'b1;
    load = 1'b1;
    clk1();
    load = 1'b0;
    clkn(28);
    chk_disp("idx7", 8, 1, 2);
    clkn(3);
    matrix_in = {N*N{8'hAA}};
    load = 1'b1;
    clk1();
    load = 1'b0;
    chk_disp("restart", 8'hAA, 0, 0);
    chk("restart busy", 32'(busy), 1);
    chk("restart done", 32'(done), 0);
    matrix_in = {N*N{8'h55}};
    clkn(4);
    chk_disp("restart adv", 8'hAA, 0, 1);

    // load held high pins the scan at element 0
    fill_seq();
    load = 1'b1;
    clkn(6);
    chk_disp("load held", 1, 0, 0);
    load = 1'b0;
    clkn(3);
    chk("load rel hold", 32'(leds), 1);
    clk1();
    chk_disp("load rel adv", 2, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
